// File: rtl/vram_console.sv
// vram_console: byte-stream text console driving the character VRAM write port.
// Handles printable bytes, LF/CR/BS/FF controls, full-screen clear and line clear.
module vram_console #(
   parameter int COLS = 40,
   parameter int ROWS = 30,
   parameter int AW = 11,
   parameter int DW = 8,
   parameter logic [DW-1:0] BLANK = 8'h20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          we,
   output logic          busy
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int N = COLS * ROWS;
   localparam logic [7:0] LF = 8'h0A, CR = 8'h0D, BS = 8'h08, FF = 8'h0C;
   typedef enum logic [1:0] {CLEAR, IDLE, PUT, LCLR} state_t;
   state_t state, state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] base, cnt, waddr_nx;
   logic [DW-1:0] chr, wdata_nx;
   logic xfer, adv, we_nx, rdy_nx, busy_nx, col_end;
   assign xfer = state == IDLE && in_valid && in_ready;
   assign col_end = col == CW'(COLS - 1);
   assign adv = (xfer && in_data == LF) || (state == PUT && col_end);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= CLEAR;
         col <= '0;
         row <= '0;
         base <= '0;
         cnt <= '0;
         chr <= '0;
      end else begin
         state <= state_nx;
         cnt <= state_nx == state ? cnt + AW'(1) : '0;
         if (xfer) chr <= DW'(in_data);
         // base tracks row*COLS incrementally so no multiplier is needed
         if (state == CLEAR) begin
            col <= '0;
            row <= '0;
            base <= '0;
         end else begin
            if (xfer && (in_data == LF || in_data == CR)) col <= '0;
            else if (xfer && in_data == BS && col != '0) col <= col - CW'(1);
            else if (state == PUT) col <= col_end ? '0 : col + CW'(1);
            if (adv) begin
               row <= row == RW'(ROWS - 1) ? '0 : row + RW'(1);
               base <= row == RW'(ROWS - 1) ? '0 : base + AW'(COLS);
            end
         end
      end
   always_comb begin
      state_nx = state;
      case (state)
         CLEAR: if (cnt == AW'(N - 1)) state_nx = IDLE;
         IDLE: if (xfer) state_nx = in_data == LF ? LCLR : in_data == FF ? CLEAR :
                                    (in_data == CR || in_data == BS) ? IDLE : PUT;
         PUT: state_nx = col_end ? LCLR : IDLE;
         LCLR: if (cnt == AW'(COLS - 1)) state_nx = IDLE;
         default: state_nx = CLEAR;
      endcase
   end
   always_comb begin
      we_nx = state != IDLE;
      waddr_nx = state == CLEAR ? cnt : base + (state == PUT ? AW'(col) : cnt);
      wdata_nx = state == PUT ? chr : BLANK;
      rdy_nx = state == IDLE && state_nx == IDLE;
      busy_nx = state == CLEAR || state == LCLR;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         we <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         in_ready <= 1'b0;
         busy <= 1'b1;
      end else begin
         we <= we_nx;
         waddr <= waddr_nx;
         wdata <= wdata_nx;
         in_ready <= rdy_nx;
         busy <= busy_nx;
      end
endmodule
